// File: rtl/gray_converter.sv
// RGB555 to gray converter feeding the sobel stage: a two-stage elastic pipeline
// producing {Y,Y,Y}, with a frame pixel counter and an end-of-frame pulse.
module gray_converter #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic        gray_clk,
  input  logic        reset,
  input  logic [14:0] in_px_rgb,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] out_px_gray,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] px_count,
  output logic        frame_done
);

  localparam logic [16:0] LAST_PX = 17'(IMG_WIDTH * IMG_HEIGHT - 1);

  logic        en;
  logic        outXfer;

  logic [11:0] prodRQ, prodRD;
  logic [12:0] prodGQ, prodGD;
  logic [9:0]  prodBQ, prodBD;
  logic        s1ValidQ, s1ValidD;

  logic [12:0] lumaSum;
  logic [4:0]  luma;
  logic [14:0] outPxQ, outPxD;
  logic        outValidQ, outValidD;

  logic [16:0] pxCountQ, pxCountD;
  logic        frameDoneQ, frameDoneD;

  // Both stages advance together whenever the output slot is free or draining.
  assign en      = out_ready | ~outValidQ;
  assign outXfer = outValidQ & out_ready;

  always_comb begin
    prodRD    = 12'(in_px_rgb[14:10]) * 12'd77;
    prodGD    = 13'(in_px_rgb[9:5])   * 13'd150;
    prodBD    = 10'(in_px_rgb[4:0])   * 10'd29;
    s1ValidD  = in_valid;
    // Coefficients sum to 256, so the 13-bit sum never exceeds 31*256.
    lumaSum   = 13'(prodRQ) + prodGQ + 13'(prodBQ);
    luma      = 5'(lumaSum >> 8);
    outPxD    = {luma, luma, luma};
    outValidD = s1ValidQ;
  end

  always_comb begin
    pxCountD   = pxCountQ;
    frameDoneD = 1'b0;
    if (outXfer) begin
      if (pxCountQ == LAST_PX) begin
        pxCountD   = '0;
        frameDoneD = 1'b1;
      end else begin
        pxCountD   = pxCountQ + 17'd1;
      end
    end
  end

  always_ff @(posedge gray_clk or posedge reset) begin
    if (reset) begin
      prodRQ    <= '0;
      prodGQ    <= '0;
      prodBQ    <= '0;
      s1ValidQ  <= 1'b0;
      outPxQ    <= '0;
      outValidQ <= 1'b0;
    end else if (en) begin
      prodRQ    <= prodRD;
      prodGQ    <= prodGD;
      prodBQ    <= prodBD;
      s1ValidQ  <= s1ValidD;
      outPxQ    <= outPxD;
      outValidQ <= outValidD;
    end
  end

  always_ff @(posedge gray_clk or posedge reset) begin
    if (reset) begin
      pxCountQ   <= '0;
      frameDoneQ <= 1'b0;
    end else begin
      pxCountQ   <= pxCountD;
      frameDoneQ <= frameDoneD;
    end
  end

  assign in_ready    = en;
  assign out_px_gray = outPxQ;
  assign out_valid   = outValidQ;
  assign px_count    = pxCountQ;
  assign frame_done  = frameDoneQ;

endmodule

// File: tb/tb_gray_converter.sv
// Self-checking bench for gray_converter: a queue-based reference model of the
// pixel stream, random handshakes, stalls, frame wrap and asynchronous reset.
module tb_gray_converter;

  localparam int W      = 40;
  localparam int H      = 30;
  localparam int NPX    = W * H;
  localparam int LASTPX = NPX - 1;

  logic        gray_clk = 1'b0;
  logic        reset;
  logic [14:0] in_px_rgb;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] out_px_gray;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] px_count;
  logic        frame_done;

  gray_converter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .gray_clk   (gray_clk),
    .reset      (reset),
    .in_px_rgb  (in_px_rgb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_px_gray(out_px_gray),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .px_count   (px_count),
    .frame_done (frame_done)
  );

  always #5 gray_clk = ~gray_clk;

  int nChecks = 0;
  int nFails  = 0;

  logic [14:0] expQ[$];
  int          modelCnt  = 0;
  logic        fdPending = 1'b0;

  logic        sInX, sOutX, sOutValid, sInReady, sFd, sExpFd, sHaveExp;
  logic [14:0] sPx, sExpPx;
  logic [16:0] sCnt, sExpCnt;

  function automatic logic [14:0] refGray(input logic [14:0] rgb);
    int r = int'(rgb[14:10]);
    int g = int'(rgb[9:5]);
    int b = int'(rgb[4:0]);
    int y = (77 * r + 150 * g + 29 * b) / 256;
    logic [4:0] y5 = 5'(y);
    return {y5, y5, y5};
  endfunction

  // One cycle: drive at the falling edge, sample 1ns later, update the model
  // with the transfers that the next rising edge will perform.
  task automatic stepCycle(input logic v, input logic [14:0] px, input logic ordy);
    in_valid  = v;
    in_px_rgb = px;
    out_ready = ordy;
    #1;
    sOutValid = out_valid;
    sInReady  = in_ready;
    sPx       = out_px_gray;
    sCnt      = px_count;
    sFd       = frame_done;
    sInX      = v && in_ready;
    sOutX     = out_valid && ordy;
    sExpFd    = fdPending;
    fdPending = 1'b0;
    sHaveExp  = 1'b0;
    sExpPx    = '0;
    sExpCnt   = '0;
    if (sOutX) begin
      sExpCnt   = 17'(modelCnt);
      fdPending = (modelCnt == LASTPX);
      modelCnt  = (modelCnt == LASTPX) ? 0 : modelCnt + 1;
      if (expQ.size() > 0) begin
        sExpPx   = expQ.pop_front();
        sHaveExp = 1'b1;
      end
    end
    if (sInX) expQ.push_back(refGray(px));
    @(negedge gray_clk);
  endtask

  task automatic applyReset();
    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge gray_clk);
    @(negedge gray_clk);
    reset = 1'b0;
    expQ.delete();
    modelCnt  = 0;
    fdPending = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_px_rgb = '0;
    out_ready = 1'b0;
    @(negedge gray_clk);
    #1;
    nChecks++;
    if (out_valid !== 1'b0 || px_count !== 17'd0 || frame_done !== 1'b0 || out_px_gray !== 15'h0) begin
      nFails++;
      $display("[TB] FAIL reset_state: got valid=%b cnt=%0d fd=%b px=%h, expected 0/0/0/0000",
               out_valid, px_count, frame_done, out_px_gray);
    end
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge gray_clk);
    reset = 1'b0;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge gray_clk);
    expQ.delete();
    modelCnt  = 0;
    fdPending = 1'b0;
  endtask

  task automatic test_colours();
    logic [14:0] cin  [5] = '{15'h7FFF, 15'h7C00, 15'h03E0, 15'h001F, 15'h0000};
    logic [14:0] cexp [5] = '{15'h7FFF, 15'h2529, 15'h4A52, 15'h0C63, 15'h0000};
    for (int i = 0; i < 5; i++) begin
      stepCycle(1'b1, cin[i], 1'b1);
      nChecks++;
      if (sInX !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL colour_accept[%0d]: in_ready got %b expected 1", i, sInReady);
      end
      stepCycle(1'b0, 15'h0, 1'b1);
      nChecks++;
      if (sOutValid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL colour_latency_early[%0d]: out_valid got %b expected 0", i, sOutValid);
      end
      stepCycle(1'b0, 15'h0, 1'b1);
      nChecks++;
      if (sOutValid !== 1'b1 || sPx !== cexp[i]) begin
        nFails++;
        $display("[TB] FAIL colour_value[%0d]: got valid=%b px=%h expected valid=1 px=%h",
                 i, sOutValid, sPx, cexp[i]);
      end
      nChecks++;
      if (!sHaveExp || sPx !== sExpPx || sCnt !== sExpCnt) begin
        nFails++;
        $display("[TB] FAIL colour_model[%0d]: got px=%h cnt=%0d expected px=%h cnt=%0d",
                 i, sPx, sCnt, sExpPx, sExpCnt);
      end
    end
  endtask

  task automatic test_stall();
    logic [14:0] pix [4];
    logic [14:0] firstGray;
    int sent = 0;
    int got  = 0;
    for (int i = 0; i < 4; i++) pix[i] = 15'($urandom);
    firstGray = refGray(pix[0]);
    for (int i = 0; i < 2; i++) begin
      stepCycle(1'b1, pix[sent], 1'b1);
      if (sInX) sent++;
    end
    for (int i = 0; i < 5; i++) begin
      stepCycle(1'b1, pix[sent], 1'b0);
      if (sInX) sent++;
      nChecks++;
      if (sOutValid !== 1'b1 || sInReady !== 1'b0 || sPx !== firstGray) begin
        nFails++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b in_ready=%b px=%h expected 1/0/%h",
                 i, sOutValid, sInReady, sPx, firstGray);
      end
    end
    for (int i = 0; i < 12 && got < 4; i++) begin
      stepCycle(sent < 4, (sent < 4) ? pix[sent] : 15'h0, 1'b1);
      if (sInX) sent++;
      if (sOutX) begin
        nChecks++;
        if (got >= 4 || sPx !== refGray(pix[got]) || !sHaveExp || sPx !== sExpPx || sCnt !== sExpCnt) begin
          nFails++;
          $display("[TB] FAIL stall_order[%0d]: got px=%h cnt=%0d expected px=%h cnt=%0d",
                   got, sPx, sCnt, sExpPx, sExpCnt);
        end
        got++;
      end
    end
    nChecks++;
    if (got !== 4 || expQ.size() !== 0) begin
      nFails++;
      $display("[TB] FAIL stall_count: got %0d outputs (%0d left) expected 4 (0 left)", got, expQ.size());
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      stepCycle($urandom_range(0, 9) < 7, 15'($urandom), $urandom_range(0, 9) < 6);
      cycles++;
      if (sInX) accepted++;
      if (sOutX) begin
        nChecks++;
        if (!sHaveExp || sPx !== sExpPx || sCnt !== sExpCnt) begin
          nFails++;
          $display("[TB] FAIL random_out: got px=%h cnt=%0d expected px=%h cnt=%0d (have=%b)",
                   sPx, sCnt, sExpPx, sExpCnt, sHaveExp);
        end
      end
      nChecks++;
      if (sFd !== sExpFd) begin
        nFails++;
        $display("[TB] FAIL random_frame_done: got %b expected %b", sFd, sExpFd);
      end
    end
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      stepCycle(1'b0, 15'h0, 1'b1);
      if (sOutX) begin
        nChecks++;
        if (!sHaveExp || sPx !== sExpPx || sCnt !== sExpCnt) begin
          nFails++;
          $display("[TB] FAIL random_drain: got px=%h cnt=%0d expected px=%h cnt=%0d",
                   sPx, sCnt, sExpPx, sExpCnt);
        end
      end
    end
    stepCycle(1'b0, 15'h0, 1'b1);
    nChecks++;
    if (accepted !== 1000 || expQ.size() !== 0 || sOutValid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL random_complete: got accepted=%0d pending=%0d valid=%b expected 1000/0/0",
               accepted, expQ.size(), sOutValid);
    end
  endtask

  task automatic test_frame();
    int outs    = 0;
    int fdCount = 0;
    int cycles  = 0;
    applyReset();
    while (outs < 2 * NPX && cycles < 2 * NPX + 20) begin
      stepCycle(1'b1, 15'($urandom), 1'b1);
      cycles++;
      if (sFd === 1'b1) fdCount++;
      if (sOutX) begin
        outs++;
        nChecks++;
        if (!sHaveExp || sPx !== sExpPx || sCnt !== sExpCnt) begin
          nFails++;
          $display("[TB] FAIL frame_out[%0d]: got px=%h cnt=%0d expected px=%h cnt=%0d",
                   outs, sPx, sCnt, sExpPx, sExpCnt);
        end
      end
      nChecks++;
      if (sFd !== sExpFd) begin
        nFails++;
        $display("[TB] FAIL frame_done_timing: got %b expected %b at cycle %0d", sFd, sExpFd, cycles);
      end
    end
    stepCycle(1'b0, 15'h0, 1'b0);
    if (sFd === 1'b1) fdCount++;
    nChecks++;
    if (sFd !== 1'b1 || sCnt !== 17'd0) begin
      nFails++;
      $display("[TB] FAIL frame_end: got fd=%b cnt=%0d expected fd=1 cnt=0", sFd, sCnt);
    end
    nChecks++;
    if (fdCount !== 2 || outs !== 2 * NPX) begin
      nFails++;
      $display("[TB] FAIL frame_pulses: got %0d pulses over %0d outputs expected 2 over %0d",
               fdCount, outs, 2 * NPX);
    end
  endtask

  task automatic test_async_reset();
    int cycles = 0;
    logic [14:0] pix;
    logic seen = 1'b0;
    applyReset();
    while (modelCnt < 1000 && cycles < 1100) begin
      stepCycle(1'b1, 15'($urandom), 1'b1);
      cycles++;
      if (sOutX) begin
        nChecks++;
        if (!sHaveExp || sPx !== sExpPx || sCnt !== sExpCnt) begin
          nFails++;
          $display("[TB] FAIL areset_stream: got px=%h cnt=%0d expected px=%h cnt=%0d",
                   sPx, sCnt, sExpPx, sExpCnt);
        end
      end
    end
    in_valid = 1'b1;
    #1;
    nChecks++;
    if (px_count !== 17'd1000 || out_valid !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL areset_precondition: got cnt=%0d valid=%b expected 1000/1", px_count, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    nChecks++;
    if (out_valid !== 1'b0 || px_count !== 17'd0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL areset_immediate: got valid=%b cnt=%0d fd=%b in_ready=%b expected 0/0/0/1",
               out_valid, px_count, frame_done, in_ready);
    end
    @(posedge gray_clk);
    @(negedge gray_clk);
    reset = 1'b0;
    expQ.delete();
    modelCnt  = 0;
    fdPending = 1'b0;
    pix = 15'($urandom);
    stepCycle(1'b1, pix, 1'b1);
    nChecks++;
    if (sOutValid !== 1'b0 || sFd !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL areset_flushed: got valid=%b fd=%b expected 0/0", sOutValid, sFd);
    end
    for (int i = 0; i < 5 && !seen; i++) begin
      stepCycle(1'b0, 15'h0, 1'b1);
      if (sOutX) begin
        seen = 1'b1;
        nChecks++;
        if (sPx !== refGray(pix) || sCnt !== 17'd0) begin
          nFails++;
          $display("[TB] FAIL areset_first_out: got px=%h cnt=%0d expected px=%h cnt=0",
                   sPx, sCnt, refGray(pix));
        end
      end
    end
    nChecks++;
    if (seen !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL areset_timeout: got no output after reset, expected one");
    end
  endtask

  initial begin
    test_reset();
    test_colours();
    test_stall();
    test_random();
    test_frame();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
